// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the RAM data port between the CPU (port A) and a DMA engine (port B),
// with A-priority bounded by a starvation counter, registered read return and a sticky range error.
module ram_arbiter #(
    parameter int MEM_DEPTH = 24575,
    parameter int MAX_WAIT  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [14:0] a_addr,
    input  logic [15:0] a_wdata,
    output logic        a_gnt,
    output logic        a_rvalid,
    output logic [15:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [14:0] b_addr,
    input  logic [15:0] b_wdata,
    output logic        b_gnt,
    output logic        b_rvalid,
    output logic [15:0] b_rdata,
    output logic        ram_writeM,
    output logic [14:0] ram_address,
    output logic [15:0] ram_inM,
    input  logic [15:0] ram_outM,
    output logic        err,
    output logic [14:0] err_addr,
    input  logic        err_clr
);

    localparam logic [15:0] LP_DEPTH    = 16'(MEM_DEPTH);
    localparam logic [3:0]  LP_MAX_WAIT = 4'(MAX_WAIT);

    logic [3:0]  r_wait_cnt;
    logic        r_a_rvalid;
    logic [15:0] r_a_rdata;
    logic        r_b_rvalid;
    logic [15:0] r_b_rdata;
    logic        r_err;
    logic [14:0] r_err_addr;

    logic        w_a_gnt;
    logic        w_b_gnt;
    logic        w_any_gnt;
    logic        w_gnt_we;
    logic [14:0] w_gnt_addr;
    logic [15:0] w_gnt_wdata;
    logic        w_in_range;
    logic [15:0] w_rd_value;

    // Grants are gated by rst_n so nothing reaches the RAM while reset is held.
    assign w_b_gnt   = rst_n & b_req & (~a_req | (r_wait_cnt >= LP_MAX_WAIT));
    assign w_a_gnt   = rst_n & a_req & ~w_b_gnt;
    assign w_any_gnt = w_a_gnt | w_b_gnt;

    always_comb begin
        w_gnt_we    = 1'b0;
        w_gnt_addr  = 15'd0;
        w_gnt_wdata = 16'd0;
        if (w_b_gnt) begin
            w_gnt_we    = b_we;
            w_gnt_addr  = b_addr;
            w_gnt_wdata = b_wdata;
        end else if (w_a_gnt) begin
            w_gnt_we    = a_we;
            w_gnt_addr  = a_addr;
            w_gnt_wdata = a_wdata;
        end
    end

    assign w_in_range = ({1'b0, w_gnt_addr} < LP_DEPTH);
    assign w_rd_value = w_in_range ? ram_outM : 16'd0;

    assign ram_writeM  = w_any_gnt & w_gnt_we & w_in_range;
    assign ram_address = w_gnt_addr;
    assign ram_inM     = w_gnt_wdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 4'd0;
            r_a_rvalid <= 1'b0;
            r_a_rdata  <= 16'd0;
            r_b_rvalid <= 1'b0;
            r_b_rdata  <= 16'd0;
            r_err      <= 1'b0;
            r_err_addr <= 15'd0;
        end else begin
            r_a_rvalid <= w_a_gnt & ~a_we;
            if (w_a_gnt && !a_we) begin
                r_a_rdata <= w_rd_value;
            end
            r_b_rvalid <= w_b_gnt & ~b_we;
            if (w_b_gnt && !b_we) begin
                r_b_rdata <= w_rd_value;
            end

            if (!b_req || w_b_gnt) begin
                r_wait_cnt <= 4'd0;
            end else if (r_wait_cnt != 4'hF) begin
                r_wait_cnt <= r_wait_cnt + 4'd1;
            end

            // Clear beats a simultaneous violation; only the first offender is recorded.
            if (err_clr) begin
                r_err      <= 1'b0;
                r_err_addr <= 15'd0;
            end else if (w_any_gnt && !w_in_range) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= w_gnt_addr;
                end
            end
        end
    end

    assign a_gnt    = w_a_gnt;
    assign b_gnt    = w_b_gnt;
    assign a_rvalid = r_a_rvalid;
    assign a_rdata  = r_a_rdata;
    assign b_rvalid = r_b_rvalid;
    assign b_rdata  = r_b_rdata;
    assign err      = r_err;
    assign err_addr = r_err_addr;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus randomized traffic checked every cycle
// against a behavioural model (shadow memory, refusal count, expected returns and error state).
module tb_ram_arbiter;

    localparam int MEM_DEPTH = 24575;
    localparam int MAX_WAIT  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0, err_clr = 0;
    logic [14:0] a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;
    logic        a_gnt, a_rvalid, b_gnt, b_rvalid, ram_writeM, err;
    logic [15:0] a_rdata, b_rdata, ram_inM, ram_outM;
    logic [14:0] ram_address, err_addr;

    ram_arbiter #(.MEM_DEPTH(MEM_DEPTH), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_writeM(ram_writeM), .ram_address(ram_address), .ram_inM(ram_inM),
        .ram_outM(ram_outM), .err(err), .err_addr(err_addr), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    // RAM behind the arbiter: combinational read, write on the clock edge.
    logic [15:0] mem [0:32767];
    initial for (int i = 0; i < 32768; i++) mem[i] = 16'd0;
    always @(posedge clk) if (ram_writeM) mem[ram_address] <= ram_inM;
    assign ram_outM = mem[ram_address];

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] shadow [int unsigned];
    int          m_refusals = 0;
    logic        m_a_rvalid = 0, m_b_rvalid = 0, m_err = 0;
    logic [15:0] m_a_rdata = 0, m_b_rdata = 0;
    logic [14:0] m_err_addr = 0;
    logic        last_e_a = 0, last_e_b = 0;

    // Samples of the DUT from the most recent step
    logic        s_a_gnt, s_b_gnt, s_a_rvalid, s_b_rvalid, s_wr, s_err;
    logic [15:0] s_a_rdata, s_b_rdata;
    logic [14:0] s_err_addr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] shadow_rd(input logic [14:0] addr);
        if (int'(addr) >= MEM_DEPTH) return 16'd0;
        if (shadow.exists(int'(addr))) return shadow[int'(addr)];
        return 16'd0;
    endfunction

    task automatic model_reset();
        m_refusals = 0;
        m_a_rvalid = 0; m_b_rvalid = 0; m_a_rdata = 0; m_b_rdata = 0;
        m_err = 0; m_err_addr = 0;
        last_e_a = 0; last_e_b = 0;
    endtask

    // One clock cycle: compare at the falling edge, advance the model, return 1 unit after the rising edge.
    task automatic step();
        logic        e_a, e_b, g_we, oor;
        logic [14:0] g_addr;
        logic [15:0] g_wdata;
        @(negedge clk);
        s_a_gnt = a_gnt; s_b_gnt = b_gnt; s_a_rvalid = a_rvalid; s_b_rvalid = b_rvalid;
        s_a_rdata = a_rdata; s_b_rdata = b_rdata; s_wr = ram_writeM;
        s_err = err; s_err_addr = err_addr;

        e_b = b_req && (!a_req || m_refusals >= MAX_WAIT);
        e_a = a_req && !e_b;
        g_we = e_b ? b_we : (e_a ? a_we : 1'b0);
        g_addr = e_b ? b_addr : (e_a ? a_addr : 15'd0);
        g_wdata = e_b ? b_wdata : (e_a ? a_wdata : 16'd0);
        oor = (e_a || e_b) && (int'(g_addr) >= MEM_DEPTH);

        chk("a_gnt", 32'(a_gnt), 32'(e_a));
        chk("b_gnt", 32'(b_gnt), 32'(e_b));
        chk("ram_writeM", 32'(ram_writeM), 32'((e_a || e_b) && g_we && !oor));
        chk("ram_address", 32'(ram_address), 32'(g_addr));
        chk("ram_inM", 32'(ram_inM), 32'(g_wdata));
        chk("a_rvalid", 32'(a_rvalid), 32'(m_a_rvalid));
        chk("a_rdata", 32'(a_rdata), 32'(m_a_rdata));
        chk("b_rvalid", 32'(b_rvalid), 32'(m_b_rvalid));
        chk("b_rdata", 32'(b_rdata), 32'(m_b_rdata));
        chk("err", 32'(err), 32'(m_err));
        chk("err_addr", 32'(err_addr), 32'(m_err_addr));

        m_refusals = (b_req && !e_b) ? m_refusals + 1 : 0;
        if ((e_a || e_b) && g_we && !oor) shadow[int'(g_addr)] = g_wdata;
        m_a_rvalid = e_a && !a_we;
        if (m_a_rvalid) m_a_rdata = shadow_rd(a_addr);
        m_b_rvalid = e_b && !b_we;
        if (m_b_rvalid) m_b_rdata = shadow_rd(b_addr);
        if (err_clr) begin
            m_err = 0; m_err_addr = 0;
        end else if (oor) begin
            if (!m_err) m_err_addr = g_addr;
            m_err = 1;
        end
        last_e_a = e_a; last_e_b = e_b;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [14:0] rand_addr();
        int unsigned r = $urandom_range(7);
        if (r <= 4) return 15'($urandom_range(63));
        if (r <= 6) return 15'(24570 + $urandom_range(9));
        return 15'($urandom_range(32767));
    endfunction

    task automatic idle();
        a_req = 0; b_req = 0; a_we = 0; b_we = 0; err_clr = 0;
    endtask

    initial begin
        // Reset state with requests pending
        a_req = 1; b_req = 1; a_we = 1; b_we = 1;
        #12;
        chk("rst a_gnt", 32'(a_gnt), 0);
        chk("rst b_gnt", 32'(b_gnt), 0);
        chk("rst writeM", 32'(ram_writeM), 0);
        chk("rst rvalid", 32'({a_rvalid, b_rvalid}), 0);
        chk("rst rdata", 32'({a_rdata, b_rdata}), 0);
        chk("rst err", 32'({err, err_addr}), 0);
        idle();
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();

        // 1: A write then read back
        a_req = 1; a_we = 1; a_addr = 15'd100; a_wdata = 16'h1234;
        step();
        chk("t1 wr gnt", 32'(s_a_gnt), 1);
        a_we = 0;
        step();
        chk("t1 rd gnt", 32'(s_a_gnt), 1);
        idle();
        step();
        chk("t1 rvalid", 32'(s_a_rvalid), 1);
        chk("t1 rdata", 32'(s_a_rdata), 32'h1234);

        // 2: both requesting continuously, B forced through every fifth cycle
        for (int k = 0; k < 10; k++) begin
            a_req = 1; a_we = 0; a_addr = 15'(k);
            b_req = 1; b_we = 0; b_addr = 15'(k + 32);
            step();
            chk("t2 b_gnt", 32'(s_b_gnt), 32'(k % 5 == 4));
            chk("t2 a_gnt", 32'(s_a_gnt), 32'(k % 5 != 4));
        end
        idle();
        step();

        // 3: B alone at the last legal word
        b_req = 1; b_we = 1; b_addr = 15'd24574; b_wdata = 16'hBEEF;
        step();
        chk("t3 wr gnt", 32'(s_b_gnt), 1);
        b_we = 0;
        step();
        idle();
        step();
        chk("t3 rvalid", 32'(s_b_rvalid), 1);
        chk("t3 rdata", 32'(s_b_rdata), 32'hBEEF);
        chk("t3 err", 32'(s_err), 0);

        // 4: out-of-range writes, first offender kept, then clear
        a_req = 1; a_we = 1; a_addr = 15'd24575; a_wdata = 16'h5555;
        step();
        chk("t4 wr1 writeM", 32'(s_wr), 0);
        a_addr = 15'd30000;
        step();
        chk("t4 wr2 writeM", 32'(s_wr), 0);
        chk("t4 err", 32'(s_err), 1);
        idle();
        step();
        chk("t4 err_addr", 32'(s_err_addr), 32'd24575);
        err_clr = 1;
        step();
        idle();
        step();
        chk("t4 clr err", 32'({s_err, s_err_addr}), 0);

        // 6: clear coincides with a new violation
        a_req = 1; a_we = 0; a_addr = 15'd26000;
        step();
        idle();
        b_req = 1; b_we = 0; b_addr = 15'd25000; err_clr = 1;
        step();
        chk("t6 err before", 32'(s_err), 1);
        idle();
        step();
        chk("t6 err", 32'(s_err), 0);
        chk("t6 err_addr", 32'(s_err_addr), 0);

        // 5: reset asserted mid-cycle with a read return outstanding
        a_req = 1; a_we = 0; a_addr = 15'd100;
        step();
        #2;
        rst_n = 0;
        #1;
        chk("t5 a_gnt", 32'(a_gnt), 0);
        chk("t5 a_rvalid", 32'(a_rvalid), 0);
        chk("t5 a_rdata", 32'(a_rdata), 0);
        a_we = 1; a_wdata = 16'hFFFF;
        @(posedge clk); #1;
        chk("t5 writeM", 32'(ram_writeM), 0);
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
        idle();
        step();
        chk("t5 no rvalid", 32'(s_a_rvalid), 0);
        a_req = 1; a_we = 0; a_addr = 15'd100;
        step();
        idle();
        step();
        chk("t5 rdata kept", 32'(s_a_rdata), 32'h1234);

        // Randomized traffic; requests held until granted
        for (int c = 0; c < 3000; c++) begin
            if (!a_req || last_e_a) begin
                a_req = ($urandom_range(2) != 0);
                a_we = $urandom_range(1) == 1;
                a_addr = rand_addr();
                a_wdata = 16'($urandom);
            end
            if (!b_req || last_e_b) begin
                b_req = ($urandom_range(2) != 0);
                b_we = $urandom_range(1) == 1;
                b_addr = rand_addr();
                b_wdata = 16'($urandom);
            end
            err_clr = ($urandom_range(15) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
